// File: rtl/mito_post_pool.sv
// mito_post_pool: per-lane requantise (round/shift/saturate), optional ReLU,
// optional 2x2 stride-2 max pool, streaming raster order over valid/ready.
// Optional build macro MITO_POST_STATS_EN adds the sat_count output.
module mito_post_pool #(
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 8,
  parameter int CHANNELS = 4,
  parameter int MAX_COLS = 32,
  parameter int DIM_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DIM_W-1:0]             cfg_cols,
  input  logic [DIM_W-1:0]             cfg_rows,
  input  logic [4:0]                   cfg_shift,
  input  logic [1:0]                   cfg_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*OUT_W-1:0]    out_data,
  output logic                         out_last,
  output logic                         busy
`ifdef MITO_POST_STATS_EN
  ,
  output logic [15:0]                  sat_count
`endif
);

  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic signed [DATA_W:0] SAT_HI = (DATA_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state_reg, state_next;
  logic [DIM_W-1:0]             cols_reg, rows_reg, col_reg, row_reg;
  logic [4:0]                   shift_reg;
  logic [1:0]                   mode_reg;
  logic                         fire, at_last, emit, pool_last;
  logic [DIM_W-1:0]             last_pcol, last_prow;
  logic [CHANNELS*OUT_W-1:0]    q_vec, pool_vec, m_vec, pair_reg, lb_rd_reg;
  logic [CHANNELS*OUT_W-1:0]    linebuf [LB_DEPTH];
  logic [LB_AW-1:0]             lb_addr;
`ifdef MITO_POST_STATS_EN
  logic [CHANNELS-1:0]          sat_vec;
  logic [16:0]                  sat_sum;
`endif

  assign busy      = (state_reg != IDLE);
  assign fire      = in_valid && in_ready;
  assign at_last   = (row_reg == rows_reg - DIM_W'(1)) && (col_reg == cols_reg - DIM_W'(1));
  // Final pooled beat sits at the last odd row/col of the even-trimmed frame.
  assign last_pcol = {cols_reg[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign last_prow = {rows_reg[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign pool_last = (row_reg == last_prow) && (col_reg == last_pcol);
  assign emit      = fire && (!mode_reg[1] || (row_reg[0] && col_reg[0]));
  assign lb_addr   = col_reg[LB_AW:1];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic signed [DATA_W-1:0] x;
      logic        [DATA_W:0]   rnd;
      logic signed [DATA_W:0]   sum, shifted;
      logic                     hi, lo;
      logic signed [OUT_W-1:0]  r, pair_l, lb_l, m, p;

      // Requantise one lane: round half up, arithmetic shift, clip, ReLU.
      always_comb begin
        x       = in_data[gi*DATA_W +: DATA_W];
        rnd     = ({{DATA_W{1'b0}}, 1'b1} << shift_reg) >> 1;
        sum     = {x[DATA_W-1], x} + rnd;
        shifted = sum >>> shift_reg;
        hi      = shifted > SAT_HI;
        lo      = shifted < SAT_LO;
        r       = shifted[OUT_W-1:0];
        if (hi) r = SAT_HI[OUT_W-1:0];
        if (lo) r = SAT_LO[OUT_W-1:0];
        if (mode_reg[0] && r[OUT_W-1]) r = '0;
        pair_l  = pair_reg[gi*OUT_W +: OUT_W];
        lb_l    = lb_rd_reg[gi*OUT_W +: OUT_W];
        m       = (pair_l > r) ? pair_l : r;
        p       = (lb_l > m) ? lb_l : m;
      end

      assign q_vec[gi*OUT_W +: OUT_W]    = r;
      assign m_vec[gi*OUT_W +: OUT_W]    = m;
      assign pool_vec[gi*OUT_W +: OUT_W] = p;
`ifdef MITO_POST_STATS_EN
      assign sat_vec[gi] = hi | lo;
`endif
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state and input handshake; single output register means no skid.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && at_last) state_next = DRAIN;
      end
      DRAIN: if (!out_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Config latch, raster counters and even-column pair register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cols_reg  <= '0;
      rows_reg  <= '0;
      shift_reg <= '0;
      mode_reg  <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      pair_reg  <= '0;
    end else if (state_reg == IDLE && start) begin
      cols_reg  <= cfg_cols;
      rows_reg  <= cfg_rows;
      shift_reg <= cfg_shift;
      mode_reg  <= cfg_mode;
      col_reg   <= '0;
      row_reg   <= '0;
    end else if (fire) begin
      if (!col_reg[0]) pair_reg <= q_vec;
      if (col_reg == cols_reg - DIM_W'(1)) begin
        col_reg <= '0;
        row_reg <= row_reg + DIM_W'(1);
      end else begin
        col_reg <= col_reg + DIM_W'(1);
      end
    end
  end

  // Line buffer: pair maxima written on even rows, read one beat ahead on odd rows.
  always_ff @(posedge clk) begin
    if (fire && mode_reg[1]) begin
      if (col_reg[0] && !row_reg[0]) linebuf[lb_addr] <= m_vec;
      if (!col_reg[0])               lb_rd_reg <= linebuf[lb_addr];
    end
  end

  // Output register: loads on an emitting beat, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= mode_reg[1] ? pool_vec : q_vec;
      out_last  <= mode_reg[1] ? pool_last : at_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MITO_POST_STATS_EN
  // Saturating count of clipped lane results over accepted beats.
  always_comb begin
    sat_sum = {1'b0, sat_count};
    for (int i = 0; i < CHANNELS; i++) sat_sum = sat_sum + 17'(sat_vec[i]);
  end

  // Stats counter register; cleared on reset and on frame start.
  always_ff @(posedge clk) begin
    if (!rst_n)                          sat_count <= '0;
    else if (state_reg == IDLE && start) sat_count <= '0;
    else if (fire)                       sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif

endmodule
